// File: rtl/riscv_lsu_mem_adapter.sv
// Purpose: adapts byte/half/word core loads and stores onto a 32-bit Avalon-MM RAM port, splitting word-crossing accesses.
// Latency: response 2 (aligned store), 3 (split store / aligned load) or 4 (split load) cycles after the accept edge.
// Backpressure: req_ready is high only when idle; rsp_valid is a one-cycle pulse with no backpressure.
module riscv_lsu_mem_adapter #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  chipselect,
  output logic                  write,
  output logic [3:0]            byteenable,
  output logic [31:0]           writedata,
  output logic                  clken,
  input  logic [31:0]           readdata
);

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    unsigned_q, unsigned_d;
  logic                    write_q, write_d;
  logic [7:0]              be64_q, be64_d;
  logic [31:0]             wd_hi_q, wd_hi_d;
  logic [31:0]             rd0_q, rd0_d;
  logic [31:0]             rd1_q, rd1_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [31:0]             writedata_q, writedata_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;

  logic [3:0]              acc_mask;
  logic [7:0]              acc_be64;
  logic [63:0]             acc_wd64;
  logic                    split;
  logic [31:0]             load_result;
  logic                    addr_hi_unused;

  // Byte address bits above the RAM's reach are deliberately ignored.
  assign addr_hi_unused = ^req_addr[31:ADDR_WIDTH+2];

  assign clken     = 1'b1;
  assign address   = address_q;
  assign writedata = writedata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign split     = |be64_q[7:4];

  // Byte-lane window and shifted store data for the request being offered.
  always_comb begin
    acc_mask = 4'b1111;
    if (req_size == 2'b00) acc_mask = 4'b0001;
    else if (req_size == 2'b01) acc_mask = 4'b0011;
    acc_be64 = {4'b0000, acc_mask} << req_addr[1:0];
    acc_wd64 = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  end

  // Recombine the two read words, align to the byte offset and extend.
  always_comb begin
    logic [31:0] lo, hi, res;
    logic [63:0] win;
    lo  = split ? rd0_q : readdata;
    hi  = split ? readdata : 32'h0;
    win = {hi, lo} >> {off_q, 3'b000};
    res = win[31:0];
    case (size_q)
      2'b00:   load_result = {{24{~unsigned_q & res[7]}}, res[7:0]};
      2'b01:   load_result = {{16{~unsigned_q & res[15]}}, res[15:0]};
      default: load_result = res;
    endcase
  end

  // Next-state and RAM strobe generation.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    write_d     = write_q;
    be64_d      = be64_q;
    wd_hi_d     = wd_hi_q;
    rd0_d       = rd0_q;
    rd1_d       = rd1_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    chipselect  = 1'b0;
    write       = 1'b0;
    byteenable  = 4'b0000;
    rsp_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d     = ISSUE0;
          off_d       = req_addr[1:0];
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          write_d     = req_write;
          be64_d      = acc_be64;
          wd_hi_d     = acc_wd64[63:32];
          address_d   = req_addr[ADDR_WIDTH+1:2];
          writedata_d = acc_wd64[31:0];
        end
      end
      ISSUE0: begin
        chipselect = 1'b1;
        write      = write_q;
        byteenable = be64_q[3:0];
        if (split) begin
          state_d     = ISSUE1;
          // address_q still holds word0 here; the increment wraps at the top of the RAM.
          address_d   = address_q + ADDR_WIDTH'(1);
          writedata_d = wd_hi_q;
        end else if (write_q) begin
          state_d     = RESP;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
        end
      end
      ISSUE1: begin
        chipselect = 1'b1;
        write      = write_q;
        byteenable = be64_q[7:4];
        if (write_q) begin
          state_d     = RESP;
          rsp_rdata_d = 32'h0;
        end else begin
          // Data arriving now answers the word0 access issued last cycle.
          rd0_d   = readdata;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (split) rd1_d = readdata;
        else       rd0_d = readdata;
        rsp_rdata_d = load_result;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      write_q     <= 1'b0;
      be64_q      <= 8'h00;
      wd_hi_q     <= 32'h0;
      rd0_q       <= 32'h0;
      rd1_q       <= 32'h0;
      address_q   <= '0;
      writedata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      write_q     <= write_d;
      be64_q      <= be64_d;
      wd_hi_q     <= wd_hi_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu_mem_adapter.sv
// Purpose: self-checking bench for riscv_lsu_mem_adapter against a byte-array memory model.
// Latency: checks response cycle counts and per-cycle RAM accesses for every request.
// Backpressure: drives junk requests while busy to confirm they are ignored.
module tb_riscv_lsu_mem_adapter;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = 32'h0;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write;
  logic [3:0]    byteenable;
  logic [31:0]   writedata;
  logic          clken;
  logic [31:0]   readdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:8191];
  logic [7:0]  ref_mem [0:32767];
  logic        mem_init = 1'b0;
  logic [31:0] ram_tmp;

  riscv_lsu_mem_adapter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .address(address), .chipselect(chipselect), .write(write),
    .byteenable(byteenable), .writedata(writedata), .clken(clken),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] wv;
    wv = 32'(w);
    return (wv * 32'h9E3779B9) ^ 32'hA5A50F0F;
  endfunction

  // RAM port model: registered read of old data, byte-masked write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 8192; w++) mem[w] <= init_word(w);
    end else if (chipselect) begin
      if (write) begin
        ram_tmp = mem[address];
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) ram_tmp[8*b +: 8] = writedata[8*b +: 8];
        mem[address] <= ram_tmp;
      end else begin
        readdata <= mem[address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_junk();
    req_valid    = 1'($urandom);
    req_addr     = $urandom;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = $urandom;
  endtask

  // One complete request; expectations come from byte-level memory semantics.
  task automatic run_req(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, output logic [31:0] got);
    logic [14:0] a;
    int          o, n, nacc, lat, exp_lat;
    logic        split;
    logic [12:0] ew [2];
    logic [3:0]  eb [2];
    logic [63:0] wd64;
    logic [31:0] exp_rd;
    a     = addr[14:0];
    o     = int'(a[1:0]);
    n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    split = (o + n) > 4;
    ew[0] = a[14:2];
    ew[1] = a[14:2] + 13'd1;
    eb[0] = 4'b0000;
    eb[1] = 4'b0000;
    for (int i = 0; i < n; i++) eb[(o + i) / 4][(o + i) % 4] = 1'b1;
    wd64    = {32'h0, wd} << (8 * o);
    exp_lat = wr ? (split ? 3 : 2) : (split ? 4 : 3);
    exp_rd  = 32'h0;
    if (!wr) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[a + 15'(i)];
      if (!uns && n < 4 && exp_rd[8*n-1])
        for (int i = 8 * n; i < 32; i++) exp_rd[i] = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[a + 15'(i)] = wd[8*i +: 8];
    end

    check("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    nacc = 0;
    lat  = 0;
    got  = 32'h0;
    for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
      check("busy_ready", {31'h0, req_ready}, 32'h0);
      if (chipselect) begin
        if (nacc < 2) begin
          check("ram_addr", {19'h0, address}, {19'h0, ew[nacc]});
          check("ram_be", {28'h0, byteenable}, {28'h0, eb[nacc]});
          check("ram_write", {31'h0, write}, {31'h0, wr});
          if (wr) check("ram_wdata", writedata, (nacc == 0) ? wd64[31:0] : wd64[63:32]);
        end
        nacc++;
      end
      if (rsp_valid) begin
        lat = cyc;
        got = rsp_rdata;
      end else begin
        drive_junk();
        @(posedge clk);
        #1;
      end
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("num_access", 32'(nacc), split ? 32'd2 : 32'd1);
    check("rsp_rdata", got, exp_rd);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] w;
    logic [31:0] addr;
    for (int i = 0; i < 8192; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = w[8*b +: 8];
    end

    #1 reset = 1'b1;
    mem_init = 1'b1;
    @(posedge clk);
    #1 mem_init = 1'b0;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_cs", {31'h0, chipselect}, 32'h0);
    check("rst_rsp", {31'h0, rsp_valid}, 32'h0);
    check("rst_clken", {31'h0, clken}, 32'h1);
    check("rst_addr", {19'h0, address}, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    run_req(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, got);
    check("sw_rsp_zero", got, 32'h0);
    run_req(32'h10, 1'b1, 2'b10, 1'b0, 32'h80FF1234, got);
    run_req(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, got);
    check("lb_signed", got, 32'hFFFFFF80);
    run_req(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, got);
    check("lbu", got, 32'h00000080);
    run_req(32'h6, 1'b1, 2'b10, 1'b0, 32'h11223344, got);
    run_req(32'h4, 1'b1, 2'b10, 1'b0, 32'hAB000000, got);
    run_req(32'h8, 1'b1, 2'b10, 1'b0, 32'h000000CD, got);
    run_req(32'h7, 1'b0, 2'b01, 1'b1, 32'h0, got);
    check("lhu_split", got, 32'h0000CDAB);
    run_req(32'h7, 1'b0, 2'b01, 1'b0, 32'h0, got);
    check("lh_split", got, 32'hFFFFCDAB);
    run_req(32'h7FFC, 1'b1, 2'b10, 1'b0, 32'h5678AAAA, got);
    run_req(32'h0, 1'b1, 2'b10, 1'b0, 32'hBBBB1234, got);
    run_req(32'h7FFE, 1'b0, 2'b10, 1'b0, 32'h0, got);
    check("lw_wrap", got, 32'h12345678);

    // Reset in the middle of a split load.
    req_valid = 1'b1; req_addr = 32'h21; req_write = 1'b0;
    req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_cs", {31'h0, chipselect}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_cs", {31'h0, chipselect}, 32'h0);
    check("arst_write", {31'h0, write}, 32'h0);
    check("arst_be", {28'h0, byteenable}, 32'h0);
    check("arst_addr", {19'h0, address}, 32'h0);
    check("arst_wdata", writedata, 32'h0);
    check("arst_rsp", {31'h0, rsp_valid}, 32'h0);
    check("arst_rdata", rsp_rdata, 32'h0);
    check("arst_clken", {31'h0, clken}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("arst_hold_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("post_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    run_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, got);
    check("post_rst_load", got, 32'h80FF1234);

    // Randomized traffic concentrated near both ends of the RAM.
    for (int k = 0; k < 300; k++) begin
      case ($urandom % 4)
        0:       addr = $urandom % 64;
        1:       addr = 32'h7FC0 + ($urandom % 64);
        2:       addr = $urandom;
        default: addr = ($urandom % 64) | ($urandom << 15);
      endcase
      run_req(addr, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
